// File: rtl/disp_sched.sv
// Display scheduler for the RPN calculator's seven-segment path: selects stack top,
// operand entry, stack depth (peek) or a blinking error, and registers the result.
module disp_sched #(
  parameter int BLINK_HALF  = 4,
  parameter int ERR_BLINKS  = 3,
  parameter int PEEK_CYCLES = 8,
  parameter int CW          = 26
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] topVal,
  input  logic       stackEmpty,
  input  logic [3:0] depth,
  input  logic [7:0] entryVal,
  input  logic       entryActive,
  input  logic       modePulse,
  input  logic       peekPulse,
  input  logic       errPulse,
  output logic [7:0] dispVal,
  output logic       hexSel,
  output logic       dispEn,
  output logic       errActive,
  output logic [1:0] state
);

  // state | meaning
  // TOP   | show stack top, blank when the stack is empty
  // ENTRY | show the operand being keyed
  // PEEK  | show stack depth for PEEK_CYCLES cycles
  // ERR   | blink 8'hEE for ERR_BLINKS on/off pairs
  localparam logic [1:0] S_TOP   = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_PEEK  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam int BCW = $clog2(2 * ERR_BLINKS) + 1;
  localparam logic [BCW-1:0] LAST_HALF  = BCW'(2 * ERR_BLINKS - 1);
  localparam logic [CW-1:0]  BLINK_LOAD = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0]  PEEK_LOAD  = CW'(PEEK_CYCLES - 1);
  localparam logic [7:0]     ERR_GLYPH  = 8'hEE;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  timer_q, timer_d;
  logic [BCW-1:0] blink_q, blink_d;
  logic           hex_mode_q, hex_mode_d;
  logic [7:0]     disp_val_q, disp_val_d;
  logic           hex_sel_q, hex_sel_d;
  logic           disp_en_q, disp_en_d;
  logic           err_active_q, err_active_d;

  logic       timer_done;
  logic [1:0] resume_state;

  assign timer_done   = (timer_q == '0);
  assign resume_state = entryActive ? S_ENTRY : S_TOP;

  // Next-state and timer control.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    blink_d    = blink_q;
    hex_mode_d = hex_mode_q;

    if (modePulse && !errPulse && (state_q != S_ERR)) begin
      hex_mode_d = ~hex_mode_q;
    end

    if (errPulse) begin
      state_d = S_ERR;
      timer_d = BLINK_LOAD;
      blink_d = '0;
    end else begin
      case (state_q)
        S_ERR: begin
          if (!timer_done) begin
            timer_d = timer_q - 1'b1;
          end else if (blink_q == LAST_HALF) begin
            state_d = resume_state;
          end else begin
            blink_d = blink_q + 1'b1;
            timer_d = BLINK_LOAD;
          end
        end
        S_PEEK: begin
          if (peekPulse) begin
            timer_d = PEEK_LOAD;
          end else if (!timer_done) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = resume_state;
          end
        end
        default: begin
          if (peekPulse) begin
            state_d = S_PEEK;
            timer_d = PEEK_LOAD;
          end else begin
            state_d = resume_state;
          end
        end
      endcase
    end
  end

  // Outputs are a function of the upcoming state so they land one cycle after the input.
  always_comb begin
    disp_val_d   = topVal;
    hex_sel_d    = hex_mode_d;
    disp_en_d    = ~stackEmpty;
    err_active_d = 1'b0;

    case (state_d)
      S_ENTRY: begin
        disp_val_d = entryVal;
        disp_en_d  = 1'b1;
      end
      S_PEEK: begin
        disp_val_d = {4'b0000, depth};
        hex_sel_d  = 1'b0;
        disp_en_d  = 1'b1;
      end
      S_ERR: begin
        disp_val_d   = ERR_GLYPH;
        hex_sel_d    = 1'b1;
        // Even half-periods are the "on" phase.
        disp_en_d    = ~blink_d[0];
        err_active_d = 1'b1;
      end
      default: begin
        disp_val_d = topVal;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_TOP;
      timer_q      <= '0;
      blink_q      <= '0;
      hex_mode_q   <= 1'b0;
      disp_val_q   <= 8'h00;
      hex_sel_q    <= 1'b0;
      disp_en_q    <= 1'b1;
      err_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      blink_q      <= blink_d;
      hex_mode_q   <= hex_mode_d;
      disp_val_q   <= disp_val_d;
      hex_sel_q    <= hex_sel_d;
      disp_en_q    <= disp_en_d;
      err_active_q <= err_active_d;
    end
  end

  assign dispVal   = disp_val_q;
  assign hexSel    = hex_sel_q;
  assign dispEn    = disp_en_q;
  assign errActive = err_active_q;
  assign state     = state_q;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: directed scenarios plus randomized traffic, each cycle
// compared against a cycle-count model of the display rules.
module tb_disp_sched;

  localparam int BH = 4;
  localparam int EB = 3;
  localparam int PC = 8;

  logic       clock;
  logic       reset_n;
  logic [7:0] topVal;
  logic       stackEmpty;
  logic [3:0] depth;
  logic [7:0] entryVal;
  logic       entryActive;
  logic       modePulse;
  logic       peekPulse;
  logic       errPulse;
  logic [7:0] dispVal;
  logic       hexSel;
  logic       dispEn;
  logic       errActive;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // model: mode 0=top 1=entry 2=peek 3=err
  int   m_mode;
  bit   m_hex;
  int   m_peek_left;
  int   m_err_t;
  logic [12:0] exp_v;
  logic [12:0] got_v;

  disp_sched dut (
    .clock(clock), .reset_n(reset_n), .topVal(topVal), .stackEmpty(stackEmpty),
    .depth(depth), .entryVal(entryVal), .entryActive(entryActive),
    .modePulse(modePulse), .peekPulse(peekPulse), .errPulse(errPulse),
    .dispVal(dispVal), .hexSel(hexSel), .dispEn(dispEn), .errActive(errActive),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign got_v = {dispVal, hexSel, dispEn, errActive, state};

  task automatic model_reset();
    m_mode = 0; m_hex = 0; m_peek_left = 0; m_err_t = 0;
    exp_v = {8'h00, 1'b0, 1'b1, 1'b0, 2'd0};
  endtask

  task automatic model_step();
    int prev;
    logic [7:0] v;
    bit h, e, a;
    prev = m_mode;
    if (modePulse && !errPulse && prev != 3) m_hex = !m_hex;
    if (errPulse) begin
      m_mode = 3; m_err_t = 0;
    end else if (prev == 3) begin
      m_err_t++;
      if (m_err_t >= 2 * EB * BH) m_mode = entryActive ? 1 : 0;
    end else if (peekPulse) begin
      m_mode = 2; m_peek_left = PC;
    end else if (prev == 2) begin
      m_peek_left--;
      if (m_peek_left == 0) m_mode = entryActive ? 1 : 0;
    end else begin
      m_mode = entryActive ? 1 : 0;
    end
    a = 0;
    case (m_mode)
      0: begin v = topVal; h = m_hex; e = !stackEmpty; end
      1: begin v = entryVal; h = m_hex; e = 1; end
      2: begin v = {4'h0, depth}; h = 0; e = 1; end
      default: begin v = 8'hEE; h = 1; e = ((m_err_t / BH) % 2) == 0; a = 1; end
    endcase
    exp_v = {v, h, e, a, 2'(m_mode)};
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    modePulse = 0; peekPulse = 0; errPulse = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; topVal = 8'h00; stackEmpty = 1; depth = 0; entryVal = 0;
    entryActive = 0; modePulse = 0; peekPulse = 0; errPulse = 0;
    model_reset();
    repeat (2) @(negedge clock);
    total++;
    if (got_v !== 13'({8'h00, 1'b0, 1'b1, 1'b0, 2'd0})) begin
      bad++; $display("FAIL reset_vals got=%h exp=%h", got_v, 13'({8'h00, 1'b0, 1'b1, 1'b0, 2'd0}));
    end
    reset_n = 1;
    topVal = 8'hF6; stackEmpty = 0;
    tick();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL top_after_reset got=%h exp=%h", got_v, exp_v); end
    total++;
    if (dispVal !== 8'hF6) begin bad++; $display("FAIL top_val got=%h exp=f6", dispVal); end
  endtask

  task automatic test_mode();
    for (int i = 0; i < 4; i++) begin
      modePulse = (i == 0 || i == 2);
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL mode cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_entry();
    for (int i = 0; i < 6; i++) begin
      entryActive = (i < 3); entryVal = 8'd42;
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL entry cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_peek();
    int n;
    depth = 4'd5;
    peekPulse = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL peek cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
    n = 0;
    peekPulse = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (state == 2'd2) n++;
      if (i == 3) peekPulse = 1;
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL peek_reload cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
    total++;
    if (n != 12) begin bad++; $display("FAIL peek_reload_len got=%0d exp=12", n); end
  endtask

  task automatic test_err();
    logic [23:0] pat;
    pat = '0;
    errPulse = 1;
    for (int i = 0; i < 28; i++) begin
      tick();
      if (i < 24) pat = {pat[22:0], dispEn};
      if (i == 9) modePulse = 1;
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL err cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
    total++;
    if (pat !== 24'hF0F0F0) begin bad++; $display("FAIL err_blink got=%h exp=f0f0f0", pat); end
  endtask

  task automatic test_err_peek_reset();
    errPulse = 1; peekPulse = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL err_peek cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
    #2 reset_n = 0;
    #1;
    total++;
    if ({state, dispEn, errActive} !== 4'b0010) begin
      bad++; $display("FAIL async_reset got=%b exp=0010", {state, dispEn, errActive});
    end
    model_reset();
    @(negedge clock);
    reset_n = 1;
    tick();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL post_reset got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      topVal = 8'($urandom); entryVal = 8'($urandom); depth = 4'($urandom);
      stackEmpty = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) entryActive = !entryActive;
      modePulse = ($urandom_range(0, 9) == 0);
      peekPulse = ($urandom_range(0, 19) == 0);
      errPulse  = ($urandom_range(0, 59) == 0);
      tick();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL random cyc%0d got=%h exp=%h", i, got_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_entry();
    test_peek();
    test_err();
    test_err_peek_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
